phase_amp_pipe: RTL

PHASE_AMP_PIPE -- requirements
Module: phase_amp_pipe

---
 rtl/phase_amp_pipe.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/phase_amp_pipe.sv
// ---------------------------------------------------------------------------
// phase_amp_pipe
//
// Three-stage waveform generator back end. Each cycle it can accept one
// phase sample, add a phase offset to it, and turn the result into an
// unsigned offset-binary amplitude. The waveform is sine (quarter-wave
// table), triangle, square or sawtooth. The mode select travels down the
// pipe with its own sample, so a mode switch never disturbs samples that
// are already in flight.
//
// Ports
//   clk        in   1          sole clock, rising edge
//   rst        in   1          synchronous active-high reset
//   in_valid   in   1          phase/phase_off/mode hold a sample this cycle
//   phase      in   PHASE_W    accumulator phase, full scale = one period
//   phase_off  in   PHASE_W    phase offset (phase modulation input)
//   mode       in   2          0 sine, 1 triangle, 2 square, 3 sawtooth
//   out_valid  out  1          out holds a new sample this cycle
//   out        out  AMP_W      offset-binary amplitude, midscale 2^(AMP_W-1)
//
// Timing
//   The sample on the inputs in cycle c is captured by stage 1 at the end
//   of cycle c. Stage 2 captures it one edge later and stage 3 one edge
//   after that, so it is on out with out_valid high during cycle c+3.
//   Throughput is one sample per cycle and there is no backpressure.
// ---------------------------------------------------------------------------
module phase_amp_pipe #(
  parameter int PHASE_W    = 10,
  parameter int AMP_W      = 9,
  parameter int LUT_ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [PHASE_W-1:0] phase,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic [1:0]         mode,
  output logic               out_valid,
  output logic [AMP_W-1:0]   out
);

  // Number of entries in the quarter-wave table.
  localparam int TABLE_SIZE = 1 << LUT_ADDR_W;

  // Triangle works on one more phase bit than the output width: the top
  // bit picks the rising or the falling half of the period.
  localparam int TRI_W = AMP_W + 1;

  // Midscale amplitude. It is also the value out takes under reset.
  localparam logic [AMP_W-1:0] MID = AMP_W'(1) << (AMP_W - 1);

  // pi/2 as a fixed-point number with 30 fractional bits.
  localparam longint HALF_PI_FX = 64'sd1686629713;

  // Waveform select encodings, carried through the pipe with each sample.
  typedef enum logic [1:0] {
    MODE_SINE     = 2'd0,
    MODE_TRIANGLE = 2'd1,
    MODE_SQUARE   = 2'd2,
    MODE_SAW      = 2'd3
  } waveMode_t;

  // -------------------------------------------------------------------------
  // Quarter-wave table entry
  //   Q(k) = round((MID-1) * sin(pi/2 * (k + 0.5) / TABLE_SIZE))
  // The half-step offset centres every entry in its slice of the quarter
  // wave. That keeps the table symmetric under the ~a mirror used in odd
  // quadrants, and no entry is ever 0 or MID exactly.
  // The sine comes from a Taylor series in 64-bit fixed point, so the ROM
  // contents are plain integer constants when the design elaborates. With
  // x <= pi/2 and terms up to x^19, the error is many orders of magnitude
  // below one output LSB.
  // -------------------------------------------------------------------------
  function automatic logic [AMP_W-2:0] sineEntry(input int k);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint scaled;
    x      = (HALF_PI_FX * longint'(2 * k + 1)) / longint'(2 * TABLE_SIZE);
    x2     = (x * x) >>> 30;
    term   = x;
    sum    = x;
    for (int n = 1; n <= 9; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    scaled = (longint'(MID) - 64'sd1) * sum + 64'sd536870912;
    scaled = scaled >>> 30;
    return scaled[AMP_W-2:0];
  endfunction

  // Pipeline registers. The suffix gives the stage that owns the register.
  logic               r_valid1;
  logic [PHASE_W-1:0] r_p1;
  logic [1:0]         r_mode1;

  logic               r_valid2;
  logic [PHASE_W-1:0] r_p2;
  logic [1:0]         r_mode2;
  logic               r_quadHi2;
  logic [AMP_W-2:0]   r_sine2;

  logic               r_valid3;
  logic [AMP_W-1:0]   r_out3;

  // Combinational helpers.
  logic [PHASE_W-1:0]    w_sum;
  logic [1:0]            w_quad;
  logic [LUT_ADDR_W-1:0] w_addr;
  logic [LUT_ADDR_W-1:0] w_index;
  logic [AMP_W-2:0]      w_sineRom [TABLE_SIZE];
  logic [TRI_W-1:0]      w_triPhase;
  logic [AMP_W-1:0]      w_triOut;
  logic [AMP_W-1:0]      w_sawOut;
  logic [AMP_W-1:0]      w_sqOut;
  logic [AMP_W-1:0]      w_sineOut;
  logic [AMP_W-1:0]      w_nextOut;

  // -------------------------------------------------------------------------
  // Constant quarter-wave ROM. Every entry is a constant function of its
  // own index, so the table has no clock and no reset, and synthesis folds
  // it into a lookup table.
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < TABLE_SIZE; k++) begin : g_rom
    assign w_sineRom[k] = sineEntry(k);
  end

  // The phase add simply drops its carry, so it wraps modulo 2^PHASE_W.
  assign w_sum = phase + phase_off;

  // -------------------------------------------------------------------------
  // Sine addressing from the stage-1 phase. The top two bits give the
  // quadrant. The next LUT_ADDR_W bits give the position inside it. Any
  // lower bits are dropped. Odd quadrants run the table backwards,
  // which is the same as ~a.
  // -------------------------------------------------------------------------
  assign w_quad  = r_p1[PHASE_W-1 -: 2];
  assign w_addr  = r_p1[PHASE_W-3 -: LUT_ADDR_W];
  assign w_index = w_quad[0] ? ~w_addr : w_addr;

  // -------------------------------------------------------------------------
  // Triangle and sawtooth take the top bits of the stage-2 phase. If the
  // phase word is narrower than the slice, it is zero-padded on the right.
  // -------------------------------------------------------------------------
  if (PHASE_W >= TRI_W) begin : g_triSlice
    assign w_triPhase = r_p2[PHASE_W-1 -: TRI_W];
  end else begin : g_triPad
    assign w_triPhase = {r_p2, {(TRI_W - PHASE_W){1'b0}}};
  end

  if (PHASE_W >= AMP_W) begin : g_sawSlice
    assign w_sawOut = r_p2[PHASE_W-1 -: AMP_W];
  end else begin : g_sawPad
    assign w_sawOut = {r_p2, {(AMP_W - PHASE_W){1'b0}}};
  end

  // On the falling half the triangle is (2^AMP_W - 1) - u. That is the
  // bitwise inverse of u, so no subtractor is needed.
  assign w_triOut = w_triPhase[AMP_W] ? ~w_triPhase[AMP_W-1:0]
                                      : w_triPhase[AMP_W-1:0];

  // Square is high for the first half period and low for the second.
  assign w_sqOut = r_p2[PHASE_W-1] ? '0 : '1;

  // The table value is below MID, so neither the add nor the subtract
  // can wrap. The sine stays within 1 .. 2^AMP_W-1.
  assign w_sineOut = r_quadHi2 ? (MID - {1'b0, r_sine2})
                               : (MID + {1'b0, r_sine2});

  // -------------------------------------------------------------------------
  // Stage-3 waveform mux. Midscale is assigned first, so the block
  // always drives a value even though all four modes are decoded.
  // -------------------------------------------------------------------------
  always_comb begin
    w_nextOut = MID;
    case (waveMode_t'(r_mode2))
      MODE_SINE:     w_nextOut = w_sineOut;
      MODE_TRIANGLE: w_nextOut = w_triOut;
      MODE_SQUARE:   w_nextOut = w_sqOut;
      MODE_SAW:      w_nextOut = w_sawOut;
      default:       w_nextOut = MID;
    endcase
  end

  // -------------------------------------------------------------------------
  // Valid chain and output register. Reset clears every stage's valid bit,
  // so any samples in flight are dropped and never appear. in_valid is
  // ignored while rst is high, and out is forced to midscale.
  // out only loads when a valid sample reaches the last stage. Idle slots
  // therefore leave the previous amplitude on out.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid1 <= 1'b0;
      r_valid2 <= 1'b0;
      r_valid3 <= 1'b0;
      r_out3   <= MID;
    end else begin
      r_valid1 <= in_valid;
      r_valid2 <= r_valid1;
      r_valid3 <= r_valid2;
      if (r_valid2) begin
        r_out3 <= w_nextOut;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Data path registers for stages 1 and 2. These registers have no reset
  // and load every cycle. Their contents only count when the valid bit
  // that travels with them is set.
  // Stage 2 keeps only the upper quadrant bit. The lower bit has already
  // been used to mirror the table address.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    r_p1      <= w_sum;
    r_mode1   <= mode;
    r_p2      <= r_p1;
    r_mode2   <= r_mode1;
    r_quadHi2 <= w_quad[1];
    r_sine2   <= w_sineRom[w_index];
  end

  assign out_valid = r_valid3;
  assign out       = r_out3;

endmodule
